// File: rtl/alu_scheduler_pkg.sv
// Shared op-code constants, FSM state encoding and legal-op check for the ALU scheduler.
package alu_scheduler_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_scheduler_alu.sv
// ALU32Bit: 32-bit combinational datapath. Overflow is the raw add/sub overflow;
// the scheduler decides when it is meaningful.
module ALU32Bit
  import alu_scheduler_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] result,
  output logic        overflow
);

  logic [31:0] sum;
  logic [31:0] diff;
  logic        add_ovf;
  logic        sub_ovf;

  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
  assign sub_ovf = (a[31] != b[31]) && (diff[31] != a[31]);

  // SLT uses the subtract sign corrected by overflow so large-magnitude operands compare right.
  always_comb begin
    result   = 32'd0;
    overflow = op[2] ? sub_ovf : add_ovf;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = sum;
      OP_SUB:  result = diff;
      OP_SLT:  result = {31'd0, diff[31] ^ sub_ovf};
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/alu_scheduler.sv
// Two-requester round-robin front end for a single ALU: one operation in flight,
// IDLE -> EXEC -> RESP, with a saturating completed-operation counter.
module alu_scheduler
  import alu_scheduler_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [2:0]       req0_op,
  input  logic [2:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic              id_q, id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [31:0]       rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_overflow_q, rsp_overflow_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  logic        grant_valid;
  logic        grant_id;
  logic [31:0] alu_result;
  logic        alu_ovf;
  logic        op_legal;
  logic [31:0] exec_result;

  ALU32Bit u_alu (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .result   (alu_result),
    .overflow (alu_ovf)
  );

  // rr_q set means req1 has priority on the next contested grant.
  assign grant_valid = (state_q == ST_IDLE) && !reset && (req0_valid || req1_valid);
  assign grant_id    = (req0_valid && req1_valid) ? rr_q : req1_valid;
  assign req0_ready  = grant_valid && !grant_id;
  assign req1_ready  = grant_valid && grant_id;

  assign op_legal    = is_legal_op(op_q);
  assign exec_result = op_legal ? alu_result : 32'd0;

  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    a_d            = a_q;
    b_d            = b_q;
    op_d           = op_q;
    id_d           = id_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_id_d       = rsp_id_q;
    rsp_result_d   = rsp_result_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_err_d      = rsp_err_q;
    op_count_d     = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          a_d     = grant_id ? req1_a  : req0_a;
          b_d     = grant_id ? req1_b  : req0_b;
          op_d    = grant_id ? req1_op : req0_op;
          id_d    = grant_id;
          rr_d    = !grant_id;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_result_d   = exec_result;
        rsp_zero_d     = (exec_result == 32'd0);
        rsp_overflow_d = op_legal && ((op_q == OP_ADD) || (op_q == OP_SUB)) && alu_ovf;
        rsp_err_d      = !op_legal;
        rsp_id_d       = id_q;
        rsp_valid_d    = 1'b1;
        state_d        = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
          if (op_count_q != {CNT_W{1'b1}})
            op_count_d = op_count_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      rr_q           <= 1'b0;
      a_q            <= 32'd0;
      b_q            <= 32'd0;
      op_q           <= OP_AND;
      id_q           <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_result_q   <= 32'd0;
      rsp_zero_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_err_q      <= 1'b0;
      op_count_q     <= '0;
    end else begin
      state_q        <= state_d;
      rr_q           <= rr_d;
      a_q            <= a_d;
      b_q            <= b_d;
      op_q           <= op_d;
      id_q           <= id_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_result_q   <= rsp_result_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_err_q      <= rsp_err_d;
      op_count_q     <= op_count_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_err      = rsp_err_q;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler: a scoreboard queue holds the expected response of
// each accepted operation, compared while the DUT presents it.
module tb_alu_scheduler;

  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic [2:0]       req0_op, req1_op;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [31:0]      rsp_result;
  logic             rsp_zero, rsp_overflow, rsp_err;
  logic [CNT_W-1:0] op_count;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        err;
  } exp_t;

  exp_t sb[$];
  logic rr_m;
  int   cnt_m;
  int   pass_cnt  = 0;
  int   fail_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  alu_scheduler #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req1_valid   (req1_valid),
    .req0_ready   (req0_ready),
    .req1_ready   (req1_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req0_op      (req0_op),
    .req1_op      (req1_op),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .rsp_err      (rsp_err),
    .op_count     (op_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference built from signed integer arithmetic rather than bit tricks.
  function automatic exp_t model(input logic id, input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op);
    exp_t   e;
    longint wide;
    e.id  = id;
    e.ovf = 1'b0;
    e.err = 1'b0;
    e.res = 32'd0;
    case (op)
      3'b000: e.res = a & b;
      3'b001: e.res = a | b;
      3'b010: begin
        wide  = longint'($signed(a)) + longint'($signed(b));
        e.res = wide[31:0];
        e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      3'b110: begin
        wide  = longint'($signed(a)) - longint'($signed(b));
        e.res = wide[31:0];
        e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      3'b111: e.res = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
      default: e.err = 1'b1;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  task automatic applyStimulus(input logic v0, input logic v1,
                               input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1);
    logic g;
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    rsp_ready  = 1'b0;
    #1;
    g = (v0 && v1) ? rr_m : v1;
    chk("idle_req0_ready", 32'(req0_ready), 32'(!g));
    chk("idle_req1_ready", 32'(req1_ready), 32'(g));
    sb.push_back(g ? model(1'b1, a1, b1, op1) : model(1'b0, a0, b0, op0));
    rr_m = !g;
    @(posedge clk); #1;
    req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
  endtask

  task automatic checkOutput(input int hold);
    exp_t e;
    @(posedge clk); #1;
    e = sb[0];
    chk("resp_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("resp_id", 32'(rsp_id), 32'(e.id));
    chk("resp_result", rsp_result, e.res);
    chk("resp_zero", 32'(rsp_zero), 32'(e.zero));
    chk("resp_overflow", 32'(rsp_overflow), 32'(e.ovf));
    chk("resp_err", 32'(rsp_err), 32'(e.err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_result", rsp_result, e.res);
      chk("hold_zero", 32'(rsp_zero), 32'(e.zero));
      chk("hold_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("hold_op_count", 32'(op_count), 32'(cnt_m));
    end
    rsp_ready = 1'b1;
    void'(sb.pop_front());
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (cnt_m < (1 << CNT_W) - 1) cnt_m++;
    chk("after_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("after_op_count", 32'(op_count), 32'(cnt_m));
  endtask

  initial begin
    rr_m  = 1'b0;
    cnt_m = 0;
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    req0_op = 3'b000; req1_op = 3'b000;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_fields", {rsp_result[28:0], rsp_id, rsp_zero, rsp_overflow}, 32'd0);
    chk("reset_err", 32'(rsp_err), 32'd0);
    chk("reset_op_count", 32'(op_count), 32'd0);
    reset = 1'b0;

    // Contested grants alternate starting with req0.
    applyStimulus(1, 1, 3'b001, 32'hF0F0_0000, 32'h0000_0F0F, 3'b000, 32'hFFFF_0000, 32'h0F0F_FFFF);
    checkOutput(0);
    applyStimulus(1, 1, 3'b000, 32'h1234_5678, 32'h0000_0000, 3'b110, 32'h8000_0000, 32'd1);
    checkOutput(0);
    applyStimulus(1, 1, 3'b010, 32'd100, 32'd23, 3'b010, 32'hFFFF_FFFF, 32'd1);
    checkOutput(0);
    applyStimulus(1, 1, 3'b110, 32'd3, 32'd7, 3'b001, 32'd0, 32'd0);
    checkOutput(0);

    applyStimulus(1, 0, 3'b010, 32'h7FFF_FFFF, 32'd1, 3'b000, 32'd0, 32'd0);
    checkOutput(0);

    applyStimulus(0, 1, 3'b000, 32'd9, 32'd9, 3'b110, 32'd5, 32'd5);
    checkOutput(10);

    applyStimulus(1, 0, 3'b111, 32'hFFFF_FFFF, 32'd1, 3'b000, 32'd0, 32'd0);
    checkOutput(0);
    applyStimulus(1, 0, 3'b111, 32'h8000_0000, 32'd1, 3'b000, 32'd0, 32'd0);
    checkOutput(0);
    applyStimulus(1, 0, 3'b111, 32'd1, 32'hFFFF_FFFF, 3'b000, 32'd0, 32'd0);
    checkOutput(0);

    applyStimulus(1, 0, 3'b100, 32'hDEAD_BEEF, 32'h1, 3'b000, 32'd0, 32'd0);
    checkOutput(0);
    applyStimulus(1, 0, 3'b010, 32'd2, 32'd2, 3'b000, 32'd0, 32'd0);
    checkOutput(1);

    // Reset mid-EXEC drops the op; req0 then wins a contested grant.
    applyStimulus(1, 0, 3'b010, 32'd3, 32'd4, 3'b000, 32'd0, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset_op_count", 32'(op_count), 32'd0);
    reset = 1'b0;
    sb.delete();
    rr_m  = 1'b0;
    cnt_m = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("postreset_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    applyStimulus(1, 1, 3'b001, 32'h10, 32'h01, 3'b010, 32'd1, 32'd1);
    checkOutput(0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of completed-operation counter.
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  requester N has an operation.
REQ-005 SHALL have ports req0_ready/req1_ready  output  1  requester N's operation accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  32  operands.
REQ-007 SHALL have ports req0_op/req1_op  input  3  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-008 SHALL have port rsp_valid  output  1  response available.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-010 SHALL have port rsp_id  output  1  requester that owns the response.
REQ-011 SHALL have port rsp_result  output  32  ALU result.
REQ-012 SHALL have ports rsp_zero, rsp_overflow, rsp_err  output  1 each  zero flag, signed overflow (ADD/SUB only, else 0), illegal op.
REQ-013 SHALL have port op_count  output  CNT_W  completed responses, saturating.

Function
REQ-014 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; one operation outstanding at a time.
REQ-015 In IDLE, at most one readyN SHALL be high, only when its validN is high; ready SHALL be low in EXEC and RESP.
REQ-016 With one requester valid, it SHALL be granted; with both valid, the one not granted last SHALL win (round-robin, pointer initialised to favour req0).
REQ-017 On grant, a, b, op, id SHALL be registered and FSM SHALL enter EXEC; requester inputs are ignored after that edge.
REQ-018 In EXEC the registered operands SHALL drive the ALU; result and flags SHALL be registered at the end of EXEC and FSM SHALL enter RESP.
REQ-019 rsp_valid SHALL be high exactly in RESP, i.e. two cycles after the accept edge; response fields SHALL be stable while rsp_valid is high.
REQ-020 In RESP, rsp_ready high SHALL return FSM to IDLE at that edge; rsp_ready low SHALL hold RESP indefinitely.
REQ-021 No new grant SHALL occur in the RESP->IDLE cycle; earliest next accept is the cycle after return to IDLE (throughput one op per 3 cycles).
REQ-022 Ops 011, 100, 101 SHALL be accepted, produce rsp_result 0, rsp_zero 1, rsp_overflow 0, rsp_err 1.
REQ-023 SLT SHALL give result 1 when signed a < b (including overflow correction), else 0; rsp_zero reflects the 32-bit result.
REQ-024 op_count SHALL increment on each rsp_valid & rsp_ready handshake and saturate at all-ones (no wrap).
REQ-025 rsp_valid, rsp_ready and ready outputs in the same cycle SHALL not interact: arbitration is evaluated only in IDLE.

Reset
REQ-026 Reset SHALL asynchronously force: FSM IDLE, req0_ready 0, req1_ready 0, rsp_valid 0, rsp_id 0, rsp_result 0, all flags 0, op_count 0, round-robin pointer favouring req0.
REQ-027 Reset asserted in EXEC or RESP SHALL discard the in-flight operation without a response and without counting it.
REQ-028 First grant SHALL be possible in the first cycle after reset deasserts.

Structure
REQ-029 Shared package SHALL hold op-code constants (AND, OR, ADD, SUB, SLT), FSM state encoding and legal-op check function.
REQ-030 One sub-module SHALL be instantiated: the existing ALU32Bit 32-bit datapath; overflow masking and illegal-op handling live in alu_scheduler.

Verification
REQ-031 req0 ADD a=0x7FFFFFFF b=1, rsp_ready=1 -> rsp_valid 2 cycles after accept, result 0x80000000, overflow 1, zero 0, id 0.
REQ-032 Both valid every cycle, rsp_ready=1, 4 ops -> grants alternate req0, req1, req0, req1; op_count 4.
REQ-033 req1 SUB a=5 b=5, rsp_ready held low 10 cycles -> rsp_valid and result 0, zero 1 stable for 10 cycles, no readyN asserted, op_count unchanged until handshake.
REQ-034 req0 SLT a=0xFFFFFFFF b=1 -> result 1; SLT a=0x80000000 b=1 -> result 1; SLT a=1 b=0xFFFFFFFF -> result 0.
REQ-035 req0 op=100 -> rsp_err 1, result 0, zero 1; next legal op -> rsp_err 0.
REQ-036 Reset pulse during EXEC -> rsp_valid never asserts for that op, op_count 0, next accept goes to req0 when both valid.
